// File: rtl/fsmd_frame_serializer.sv
// Buffers captured words in a small FIFO and sends each one as a serial frame:
// a sync preamble, the data bits MSB-first, then a short idle gap.
module fsmd_frame_serializer #(
   parameter int         DATA_W     = 16,
   parameter int         DEPTH      = 4,
   parameter logic [3:0] PREAMBLE   = 4'b1010,
   parameter int         GAP_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [DATA_W-1:0]      data_in,
   input  logic                   data_valid,
   output logic                   ser_out,
   output logic                   ser_valid,
   output logic                   busy,
   output logic                   fifo_full,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(DATA_W);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PREAMBLE = 2'd1,
      S_DATA     = 2'd2,
      S_GAP      = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                ser_out_q, ser_out_d;
   logic                ser_valid_q, ser_valid_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                pop_s;
   logic                push_s;

   // Frame sequencing; the serial outputs are derived from the state being entered
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      pop_s     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != CW'(0)) begin
               pop_s     = 1'b1;
               shift_d   = mem_q[rd_ptr_q];
               bit_cnt_d = BW'(3);
               state_d   = S_PREAMBLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREAMBLE: begin
            if (bit_cnt_q == BW'(0)) begin
               bit_cnt_d = BW'(DATA_W - 1);
               state_d   = S_DATA;
            end else begin
               bit_cnt_d = bit_cnt_q - BW'(1);
            end
         end
         S_DATA: begin
            if (bit_cnt_q == BW'(0)) begin
               gap_cnt_d = GW'(GAP_CYCLES - 1);
               state_d   = S_GAP;
            end else begin
               shift_d   = {shift_q[DATA_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q - BW'(1);
            end
         end
         S_GAP: begin
            if (gap_cnt_q != GW'(0)) begin
               gap_cnt_d = gap_cnt_q - GW'(1);
            end else if (count_q != CW'(0)) begin
               // Chain straight into the next frame without passing through IDLE
               pop_s     = 1'b1;
               shift_d   = mem_q[rd_ptr_q];
               bit_cnt_d = BW'(3);
               state_d   = S_PREAMBLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (state_d)
         S_PREAMBLE: begin
            ser_out_d   = PREAMBLE[bit_cnt_d[1:0]];
            ser_valid_d = 1'b1;
         end
         S_DATA: begin
            ser_out_d   = shift_d[DATA_W-1];
            ser_valid_d = 1'b1;
         end
         default: begin
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
         end
      endcase
   end

   // FIFO bookkeeping; a pop in the same cycle frees the slot a full FIFO needs
   always_comb begin
      push_s     = data_valid && ((count_q != CW'(DEPTH)) || pop_s);
      overflow_d = overflow_q || (data_valid && !push_s);
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State, FIFO storage and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         if (push_s) begin
            mem_q[wr_ptr_q] <= data_in;
         end
      end
   end

   assign ser_out    = ser_out_q;
   assign ser_valid  = ser_valid_q;
   assign overflow   = overflow_q;
   assign fifo_count = count_q;
   assign fifo_full  = (count_q == CW'(DEPTH));
   assign busy       = (state_q != S_IDLE) || (count_q != CW'(0));

endmodule

// File: tb/tb_fsmd_frame_serializer.sv
// Bench for fsmd_frame_serializer: directed scenarios plus a random soak, checked
// against a timing-level reference model and a frame scoreboard.
module tb_fsmd_frame_serializer;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int FRAME  = 4 + DATA_W;
   localparam int PERIOD = FRAME + 2;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [DATA_W-1:0] din = '0;
   logic              dv = 1'b0;
   logic              ser_out, ser_valid, busy, fifo_full, overflow;
   logic [2:0]        fifo_count;

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   // Reference model: counts and frame timing only
   int k = 0;
   int mcount = 0;
   int free_at = 0;
   int last_pop = -1000;
   bit ovf = 1'b0;
   logic [DATA_W-1:0] exp_q[$];

   // Monitor frame assembly
   logic [FRAME-1:0] bits = '0;
   int nb = 0;
   int peak = 0;

   fsmd_frame_serializer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (din),
      .data_valid (dv),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: one step per rising edge while out of reset
   initial forever begin
      @(posedge clk);
      if (reset_n) begin
         int pre;
         bit pop;
         k++;
         pre = mcount;
         pop = (pre > 0) && (k >= free_at);
         if (pop) begin
            mcount--;
            free_at  = k + PERIOD;
            last_pop = k;
         end
         if (dv) begin
            if (pre < DEPTH || pop) begin
               mcount++;
               exp_q.push_back(din);
            end else begin
               ovf = 1'b1;
            end
         end
      end
   end

   // Reset discards everything, including a frame in flight
   initial forever begin
      @(negedge reset_n);
      exp_q.delete();
      mcount   = 0;
      free_at  = 0;
      last_pop = -1000;
      ovf      = 1'b0;
      nb       = 0;
      bits     = '0;
   end

   // Monitor: compare outputs each cycle and score completed frames
   initial forever begin
      @(negedge clk);
      if (checking && reset_n) begin
         check("ser_valid", 32'(ser_valid), 32'((k - last_pop) >= 0 && (k - last_pop) < FRAME));
         check("fifo_count", 32'(fifo_count), 32'(mcount));
         check("fifo_full", 32'(fifo_full), 32'(mcount == DEPTH));
         check("busy", 32'(busy), 32'((k < free_at) || (mcount > 0)));
         check("overflow", 32'(overflow), 32'(ovf));
         if (!ser_valid) begin
            check("ser_out_idle", 32'(ser_out), 32'd0);
         end else begin
            bits = {bits[FRAME-2:0], ser_out};
            nb++;
            if (nb == FRAME) begin
               nb = 0;
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", 32'(bits), 32'hFFFFFFFF);
               end else begin
                  logic [DATA_W-1:0] w;
                  w = exp_q.pop_front();
                  check("frame", 32'(bits), 32'({4'b1010, w}));
               end
            end
         end
      end
   end

   task automatic send(input logic [DATA_W-1:0] w);
      @(negedge clk);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      dv  = 1'b1;
      din = w;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
         dv = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      dv      = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ser_out", 32'(ser_out), 32'd0);
      check("rst_ser_valid", 32'(ser_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      reset_n  = 1'b1;
      checking = 1'b1;

      // Single word
      send(16'hA5C3);
      idle(30);
      check("single_busy_done", 32'(busy), 32'd0);

      // Back-to-back words
      peak = 0;
      send(16'h0001);
      send(16'h8000);
      send(16'hFFFF);
      idle(80);
      check("b2b_peak_count", 32'(peak), 32'd2);

      // Overflow: sixth word dropped
      for (int i = 1; i <= 6; i++) send(16'(i * 16'h1111));
      idle(130);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Full FIFO with a write landing on the pop edge at the end of the gap
      do_reset();
      for (int i = 1; i <= 5; i++) send(16'(i * 16'h0101));
      idle(PERIOD - 4);
      send(16'h7E7E);
      @(posedge clk);
      #1;
      check("full_pop_count", 32'(fifo_count), 32'd4);
      check("full_pop_ovf", 32'(overflow), 32'd0);
      idle(130);

      // Reset during data bit 7 of 16'hBEEF with two words queued
      do_reset();
      send(16'hBEEF);
      send(16'h1234);
      send(16'h5678);
      @(negedge clk);
      dv = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      check("mid_ser_valid", 32'(ser_valid), 32'd1);
      check("mid_ser_out_bit7", 32'(ser_out), 32'd1);
      check("mid_fifo_count", 32'(fifo_count), 32'd2);
      reset_n = 1'b0;
      #1;
      check("async_ser_out", 32'(ser_out), 32'd0);
      check("async_ser_valid", 32'(ser_valid), 32'd0);
      check("async_fifo_count", 32'(fifo_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      idle(40);
      check("post_reset_busy", 32'(busy), 32'd0);

      // Random soak
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         dv  = ($urandom_range(0, 9) < 4);
         din = 16'($urandom);
      end
      idle(150);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("partial_frame", 32'(nb), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
